// File: rtl/div_control.sv
// Iterative signed restoring divider: one quotient bit per clock, then a sign fix-up cycle.
// Define DIV_REMAINDER_EN to add the signed remainder output.
module div_control #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             exception,
  output logic             ready,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH-1:0] remainder,
`endif
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] rem_reg;
  logic             sign_q;
  logic             div0;
`ifdef DIV_REMAINDER_EN
  logic             sign_r;
`endif

  // Magnitudes read as unsigned, so |-2^(WIDTH-1)| = 2^(WIDTH-1) without overflow.
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_comb begin
    dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    dvs_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    shifted = {rem_reg, q_reg[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_reg};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      q_reg     <= '0;
      dvs_reg   <= '0;
      rem_reg   <= '0;
      sign_q    <= 1'b0;
      div0      <= 1'b0;
      quotient  <= '0;
      exception <= 1'b0;
      ready     <= 1'b0;
      busy      <= 1'b0;
`ifdef DIV_REMAINDER_EN
      sign_r    <= 1'b0;
      remainder <= '0;
`endif
    end else begin
      ready <= 1'b0;
      if (start) begin
        // A new start always wins, aborting any operation still in flight.
        state   <= RUN;
        count   <= '0;
        q_reg   <= dvd_mag;
        dvs_reg <= dvs_mag;
        rem_reg <= '0;
        sign_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        div0    <= (divisor == '0);
        busy    <= 1'b1;
`ifdef DIV_REMAINDER_EN
        sign_r  <= dividend[WIDTH-1];
`endif
      end else begin
        case (state)
          RUN: begin
            rem_reg <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            q_reg   <= {q_reg[WIDTH-2:0], ~trial[WIDTH]};
            count   <= count + 1'b1;
            if (count == LAST_ITER) begin
              state <= FIX;
            end
          end
          FIX: begin
            quotient  <= div0 ? '0 : (sign_q ? (~q_reg + 1'b1) : q_reg);
            exception <= div0;
`ifdef DIV_REMAINDER_EN
            remainder <= div0 ? '0 : (sign_r ? (~rem_reg + 1'b1) : rem_reg);
`endif
            ready     <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
